division_scheduler: RTL
=======================

Name: division_scheduler

Overview:
- Shares one multi-cycle restoring-division engine between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshake on both the request and response sides.
- Each request is sequenced through WIDTH single-bit iterations.
- Sits between client blocks needing integer quotient/remainder and replaces per-client combinational dividers, trading latency for area.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits.
- NUM_REQ, 4, number of requesters (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  NUM_REQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  divisors, same packing.
- resp_valid  output  NUM_REQ  one-hot; marks the owner of the current result.
- resp_ready  input  NUM_REQ  per-requester result accept.
- resp_y  output  WIDTH  quotient (shared bus).
- resp_remainder  output  WIDTH  remainder (shared bus).
- resp_div_zero  output  1  result came from a divide by zero.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst=1): state IDLE, rr pointer=0, req_ready=0, resp_valid=0, resp_y=0, resp_remainder=0, resp_div_zero=0, busy=0, internal regs cleared.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - Round-robin winner = first i with req_valid[i], searching from ptr upward modulo NUM_REQ.
  - req_ready[winner] is combinationally high; all other req_ready bits are 0.
  - No valid requests: stay in IDLE, req_ready=0.
- Accept edge E (valid&ready):
  - Latch a, b and owner=winner.
  - ptr <= (winner+1) mod NUM_REQ.
  - Clear quotient reg; partial remainder = {WIDTH'b0, a}.
  - If b==0, go to DONE with y=all-ones, remainder=a, div_zero=1.
  - Otherwise go to CALC with cnt=0.
- CALC:
  - Each edge performs one restoring step: shift the {rem,a} pair left 1, shift q left 1.
  - If upper half >= b, subtract b and set q[0]=1, else q[0]=0.
  - cnt increments each step; after step WIDTH (cnt==WIDTH-1 on that edge) go to DONE.
  - req_ready=0 throughout.
- Latency: resp_valid is first high in the cycle after edge E+WIDTH (17 cycles for WIDTH=16) and in the cycle after E for divide by zero.
- DONE:
  - resp_valid[owner]=1; resp_y, resp_remainder and resp_div_zero are registered and stable.
  - Hold until resp_ready[owner]=1; resp_ready of other bits is ignored.
  - Handshake edge returns to IDLE and clears resp_valid.
  - The next grant happens at the earliest the cycle after; no same-cycle turnaround.
- Requesters must hold req_valid/req_a/req_b stable until accepted. Dropping req_valid before accept is legal and simply loses arbitration.
- Operands are unsigned. Results satisfy a == y*b + remainder and remainder < b for b!=0.
- Comparison and subtraction use WIDTH+1 bits so there is no overflow when the shifted remainder's MSB is 1.
- Simultaneous requests are served one per transaction in rr order. Starvation is impossible: worst-case wait = (NUM_REQ-1) transactions.
- Mid-operation reset: any state goes to IDLE immediately, the in-flight result is discarded, no resp_valid pulse, ptr=0.
- resp outputs keep the last result after handshake (not cleared) until the next DONE; only resp_valid qualifies them.

Decomposition:
- Shared package division_pkg holds:
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - default WIDTH=16;
  - divide-by-zero quotient constant (all-ones).
- Sub-module div_step (combinational): inputs partial remainder, shifted dividend bit and divisor; outputs next remainder and quotient bit. It is reusable by a future unrolled divider.
- Round-robin grant logic stays inline.

Test Plan:
- req_a[0]=100, req_b[0]=7 on requester 0 only -> resp_valid=4'b0001 after 17 cycles, y=14, remainder=2, div_zero=0.
- Requester 2: a=0xFFFF, b=1 -> y=0xFFFF, rem=0. Requester 1: a=5, b=9 -> y=0, rem=5. Requester 3: a=0x8001, b=0x8000 -> y=1, rem=1.
- Requester 1: a=1234, b=0 -> resp_valid=4'b0010 one cycle after accept, y=0xFFFF, rem=1234, div_zero=1.
- All four req_valid high at ptr=0 -> grants in order 0,1,2,3. Then with only requesters 0 and 2 valid and ptr=0 -> grant 0, then 2, never two consecutive grants to one requester while another waits.
- resp_ready low for 10 cycles in DONE -> resp_valid and data held stable, req_ready all 0. Raise resp_ready -> one-cycle handshake, IDLE, next grant the following cycle.
- Assert rst at cnt=8 of CALC -> outputs reset immediately (async), no resp_valid. A post-reset request 50/3 -> y=16, rem=2.

Source files
------------

// File: rtl/division_pkg.sv
// Shared definitions for the time-multiplexed restoring divider.
package division_pkg;

  // Scheduler states; explicit values keep the encoding stable for debug views.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Quotient reported for a zero divisor: all ones, sliced down to WIDTH.
  localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/division_scheduler_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step
  import division_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted remainder can need WIDTH+1 bits, so compare and subtract at that width.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; restore (keep shifted value) when the divisor does not fit.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor}) begin
      rem_out = diff[WIDTH-1:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/division_scheduler.sv
// Round-robin scheduler sharing one bit-serial restoring divider between requesters.
module division_scheduler
  import division_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int NUM_REQ = 4,
  localparam int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_y,
  output logic [WIDTH-1:0]         resp_remainder,
  output logic                     resp_div_zero,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic               accept;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [CNT_W-1:0]   cnt;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // Grant is offered only while idle and out of reset.
  assign req_ready = (state == IDLE && !rst && found) ? (NUM_REQ'(1) << winner) : '0;
  assign accept    = |(req_valid & req_ready);
  assign win_a     = req_a[winner*WIDTH +: WIDTH];
  assign win_b     = req_b[winner*WIDTH +: WIDTH];
  assign busy      = (state != IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (a_reg[WIDTH-1]),
    .divisor (b_reg),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Transaction sequencer: accept, iterate WIDTH steps, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      owner          <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      rem_reg        <= '0;
      q_reg          <= '0;
      cnt            <= '0;
      resp_valid     <= '0;
      resp_y         <= '0;
      resp_remainder <= '0;
      resp_div_zero  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (accept) begin
            owner   <= winner;
            ptr     <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            a_reg   <= win_a;
            b_reg   <= win_b;
            rem_reg <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            if (win_b == '0) begin
              resp_y         <= DIV_ZERO_Q[WIDTH-1:0];
              resp_remainder <= win_a;
              resp_div_zero  <= 1'b1;
              resp_valid     <= NUM_REQ'(1) << winner;
              state          <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          a_reg   <= a_reg << 1;
          q_reg   <= {q_reg[WIDTH-2:0], q_bit};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            resp_y         <= {q_reg[WIDTH-2:0], q_bit};
            resp_remainder <= rem_next;
            resp_div_zero  <= 1'b0;
            resp_valid     <= NUM_REQ'(1) << owner;
            state          <= DONE;
          end
        end
        DONE: begin
          if (resp_ready[owner]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
